// File: rtl/bus_width_splitter.sv
// bus_width_splitter
// ------------------
// Takes one wide request (BusWidthA bits) and plays it out as
// Factor = BusWidthA/BusWidthB narrow beats on a downstream memory port,
// lowest slice first. Read data from the beats is assembled back into one
// wide response that is reported with a single-cycle resp_valid pulse.
//
// Optional feature (compile-time macro BUS_SPLIT_SKIP_EMPTY_EN):
//   when defined, write beats whose byte-enable slice is all zero are not
//   issued; a write with no enabled bytes completes without any beat.
//   Reads are always issued in full.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   req_valid     in   upstream request present
//   req_ready     out  splitter idle, request accepted when req_valid is high
//   req_addr      in   byte address (low log2(BusWidthA/8) bits ignored)
//   req_we        in   1 = write, 0 = read
//   req_w_data    in   wide write data
//   req_w_sel     in   wide byte enables
//   resp_valid    out  one-cycle pulse: request complete
//   resp_r_data   out  assembled read data (0 for writes), held until next accept
//   mem_valid     out  downstream beat presented
//   mem_ready     in   downstream beat accepted this cycle
//   mem_addr      out  beat byte address
//   mem_we        out  beat direction
//   mem_w_data    out  beat write data
//   mem_w_sel     out  beat byte enables
//   mem_r_data    in   beat read data, valid when mem_valid && mem_ready
//   dbg_state     out  current FSM state (0 = IDLE, 1 = BEAT)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Once mem_valid is raised, every mem_* output stays constant
// until the beat is taken; req_ready never depends on req_valid.

module bus_width_splitter #(
   parameter int AddrBusWidth = 32,
   parameter int BusWidthA    = 64,
   parameter int BusWidthB    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [AddrBusWidth-1:0]   req_addr,
   input  logic                      req_we,
   input  logic [BusWidthA-1:0]      req_w_data,
   input  logic [BusWidthA/8-1:0]    req_w_sel,
   output logic                      resp_valid,
   output logic [BusWidthA-1:0]      resp_r_data,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic [AddrBusWidth-1:0]   mem_addr,
   output logic                      mem_we,
   output logic [BusWidthB-1:0]      mem_w_data,
   output logic [BusWidthB/8-1:0]    mem_w_sel,
   input  logic [BusWidthB-1:0]      mem_r_data,
   output logic                      dbg_state
);

   localparam int Factor = BusWidthA / BusWidthB;
   localparam int KW     = (Factor > 1) ? $clog2(Factor) : 1;
   localparam int SelB   = BusWidthB / 8;
   localparam int OffA   = $clog2(BusWidthA / 8);
   localparam int OffB   = $clog2(BusWidthB / 8);
   localparam logic [KW-1:0] LastK = KW'(Factor - 1);
   // Clears the address bits below one wide word.
   localparam logic [AddrBusWidth-1:0] AlignMask =
      ~AddrBusWidth'((64'd1 << OffA) - 64'd1);

   if ((BusWidthA < BusWidthB) || ((BusWidthA % BusWidthB) != 0)) begin : g_bad_ratio
      $error("bus_width_splitter: BusWidthA must be a multiple of BusWidthB");
   end
   if ((BusWidthA < 8) || ((BusWidthA & (BusWidthA - 1)) != 0) ||
       (BusWidthB < 8) || ((BusWidthB & (BusWidthB - 1)) != 0)) begin : g_bad_width
      $error("bus_width_splitter: bus widths must be powers of two >= 8");
   end

   typedef enum logic {
      IDLE = 1'b0,
      BEAT = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [KW-1:0]             k_q;
   logic [AddrBusWidth-1:0]   base_q;
   logic                      we_q;
   logic [BusWidthA-1:0]      wdata_q;
   logic [BusWidthA/8-1:0]    wsel_q;
   logic [BusWidthA-1:0]      rbuf_q;

   logic                      accept;
   logic                      beat_done;
   logic [KW-1:0]             first_k;
   logic                      first_any;
   logic [KW-1:0]             next_k;
   logic                      next_any;
   logic [BusWidthA-1:0]      rbuf_merged;
   int                        k_int;

   assign req_ready = (state_q == IDLE);
   assign dbg_state = state_q;
   assign accept    = req_valid && req_ready;
   assign beat_done = (state_q == BEAT) && mem_ready;
   assign k_int     = int'(k_q);

   // Beat selection: first beat on accept, following beat after a completion.
   always_comb begin
      first_k   = '0;
      first_any = 1'b1;
      next_k    = k_q + KW'(1);
      next_any  = (k_q != LastK);
`ifdef BUS_SPLIT_SKIP_EMPTY_EN
      // Descending scan so the lowest qualifying slice wins.
      if (req_we) begin
         first_any = 1'b0;
         for (int i = Factor - 1; i >= 0; i--) begin
            if (|req_w_sel[i*SelB +: SelB]) begin
               first_k   = KW'(i);
               first_any = 1'b1;
            end
         end
      end
      if (we_q) begin
         next_k   = '0;
         next_any = 1'b0;
         for (int i = Factor - 1; i >= 0; i--) begin
            if ((i > k_int) && (|wsel_q[i*SelB +: SelB])) begin
               next_k   = KW'(i);
               next_any = 1'b1;
            end
         end
      end
`endif
   end

   // Read buffer with the current beat's data folded in.
   always_comb begin
      rbuf_merged = rbuf_q;
      if (!we_q) begin
         rbuf_merged[k_int*BusWidthB +: BusWidthB] = mem_r_data;
      end
   end

   // Downstream beat outputs; zero whenever no beat is presented.
   always_comb begin
      mem_valid  = (state_q == BEAT);
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_w_data = '0;
      mem_w_sel  = '0;
      if (state_q == BEAT) begin
         mem_addr   = base_q + (AddrBusWidth'(k_q) << OffB);
         mem_we     = we_q;
         mem_w_data = wdata_q[k_int*BusWidthB +: BusWidthB];
         mem_w_sel  = wsel_q[k_int*SelB +: SelB];
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept && first_any) state_d = BEAT;
         BEAT: if (beat_done && !next_any) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q         <= '0;
         base_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         wsel_q      <= '0;
         rbuf_q      <= '0;
         resp_valid  <= 1'b0;
         resp_r_data <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (accept) begin
            base_q  <= req_addr & AlignMask;
            we_q    <= req_we;
            wdata_q <= req_w_data;
            wsel_q  <= req_w_sel;
            rbuf_q  <= '0;
            k_q     <= first_k;
            // Nothing to issue: complete straight away with empty data.
            if (!first_any) begin
               resp_valid  <= 1'b1;
               resp_r_data <= '0;
            end
         end
         if (beat_done) begin
            rbuf_q <= rbuf_merged;
            if (next_any) begin
               k_q <= next_k;
            end else begin
               resp_valid  <= 1'b1;
               resp_r_data <= rbuf_merged;
            end
         end
      end
   end

endmodule
